// File: rtl/stage_ctrl.sv
// Multi-cycle pipeline-stage sequencer: IDLE -> IF -> ID -> EX -> MEM -> WB (-> HALT).
// Define STAGE_CTRL_SKIP_MEM_EN to bypass MEM for instructions that are not loads/stores.
module stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_i,
    output logic        ireq_o,
    input  logic        iresp_ok_i,
    output logic        dreq_o,
    input  logic        dresp_ok_i,
    input  logic        is_mem_i,
    input  logic        is_mdu_i,
    output logic        mdu_start_o,
    input  logic        mdu_done_i,
    input  logic        trap_i,
    output logic        ifu_valid,
    output logic        idu_valid,
    output logic        exu_valid,
    output logic        memu_valid,
    output logic        wb_valid,
    output logic        instr_we_o,
    output logic        pc_we_o,
    output logic        pc_trap_o,
    output logic        commit_o,
    output logic [63:0] instret_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    state_t      ex_exit_s;
    logic        mem_flag_r;
    logic        mdu_flag_r;
    logic        ex_busy_r;
    logic [4:0]  stage_r;
    logic [63:0] instret_r;

    function automatic logic [4:0] stage_onehot(input state_t st);
        logic [4:0] oh;
        case (st)
            ST_IF:   oh = 5'b10000;
            ST_ID:   oh = 5'b01000;
            ST_EX:   oh = 5'b00100;
            ST_MEM:  oh = 5'b00010;
            ST_WB:   oh = 5'b00001;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // Successor of EX: MEM always, or WB directly for non-memory ops when skipping is built in
    always_comb begin
        ex_exit_s = ST_MEM;
`ifdef STAGE_CTRL_SKIP_MEM_EN
        if (mem_flag_r) begin
            ex_exit_s = ST_MEM;
        end else begin
            ex_exit_s = ST_WB;
        end
`else
        ex_exit_s = ST_MEM;
`endif
    end

    // Next-state logic and the combinational handshake/strobe outputs
    always_comb begin
        state_s     = state_r;
        ireq_o      = 1'b0;
        instr_we_o  = 1'b0;
        dreq_o      = 1'b0;
        mdu_start_o = 1'b0;
        pc_we_o     = 1'b0;
        pc_trap_o   = 1'b0;
        commit_o    = 1'b0;
        case (state_r)
            ST_IDLE: state_s = ST_IF;
            ST_IF: begin
                ireq_o = 1'b1;
                if (iresp_ok_i) begin
                    instr_we_o = 1'b1;
                    state_s    = ST_ID;
                end else begin
                    state_s    = ST_IF;
                end
            end
            ST_ID: state_s = ST_EX;
            ST_EX: begin
                // ex_busy_r is low only in the first EX cycle, so start is a single pulse
                if (mdu_flag_r) begin
                    mdu_start_o = ~ex_busy_r;
                    if (mdu_done_i) begin
                        state_s = ex_exit_s;
                    end else begin
                        state_s = ST_EX;
                    end
                end else begin
                    state_s = ex_exit_s;
                end
            end
            ST_MEM: begin
                if (mem_flag_r) begin
                    dreq_o = 1'b1;
                    if (dresp_ok_i) begin
                        state_s = ST_WB;
                    end else begin
                        state_s = ST_MEM;
                    end
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_WB: begin
                commit_o  = 1'b1;
                pc_we_o   = 1'b1;
                pc_trap_o = trap_i;
                if (halt_i) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_IF;
                end
            end
            ST_HALT: begin
                if (halt_i) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_IF;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus registered one-hot stage flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            stage_r <= 5'b00000;
        end else begin
            state_r <= state_s;
            stage_r <= stage_onehot(state_s);
        end
    end

    // Decode flags captured at the end of ID, EX occupancy tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_flag_r <= 1'b0;
            mdu_flag_r <= 1'b0;
            ex_busy_r  <= 1'b0;
        end else begin
            ex_busy_r <= (state_r == ST_EX);
            if (state_r == ST_ID) begin
                mem_flag_r <= is_mem_i;
                mdu_flag_r <= is_mdu_i;
            end else begin
                mem_flag_r <= mem_flag_r;
                mdu_flag_r <= mdu_flag_r;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 64'd0;
        end else if (state_r == ST_WB) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign {ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid} = stage_r;
    assign instret_o = instret_r;

endmodule

// File: tb/tb_stage_ctrl.sv
// Randomized self-checking bench for stage_ctrl: a per-instruction stage plan is built
// from handshake delays and every cycle's outputs are compared against it.
module tb_stage_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_IF   = 1;
    localparam int P_ID   = 2;
    localparam int P_EX   = 3;
    localparam int P_MEM  = 4;
    localparam int P_WB   = 5;
    localparam int P_HALT = 6;
`ifdef STAGE_CTRL_SKIP_MEM_EN
    localparam bit SKIP_MEM = 1'b1;
`else
    localparam bit SKIP_MEM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i, iresp_ok_i, dresp_ok_i, is_mem_i, is_mdu_i, mdu_done_i, trap_i;
    logic        ireq_o, dreq_o, mdu_start_o;
    logic        ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid;
    logic        instr_we_o, pc_we_o, pc_trap_o, commit_o;
    logic [63:0] instret_o;

    int          n_checks = 0;
    int          n_errors = 0;
    string       cur_test = "none";
    logic        m_mem = 1'b0;
    logic        m_mdu = 1'b0;
    logic [63:0] m_instret = 64'd0;

    stage_ctrl dut (
        .clk(clk), .rst(rst), .halt_i(halt_i),
        .ireq_o(ireq_o), .iresp_ok_i(iresp_ok_i),
        .dreq_o(dreq_o), .dresp_ok_i(dresp_ok_i),
        .is_mem_i(is_mem_i), .is_mdu_i(is_mdu_i),
        .mdu_start_o(mdu_start_o), .mdu_done_i(mdu_done_i),
        .trap_i(trap_i),
        .ifu_valid(ifu_valid), .idu_valid(idu_valid), .exu_valid(exu_valid),
        .memu_valid(memu_valid), .wb_valid(wb_valid),
        .instr_we_o(instr_we_o), .pc_we_o(pc_we_o), .pc_trap_o(pc_trap_o),
        .commit_o(commit_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    function automatic logic [11:0] observed();
        return {ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid,
                ireq_o, instr_we_o, dreq_o, mdu_start_o, pc_we_o, pc_trap_o, commit_o};
    endfunction

    // One clock cycle in a given expected stage: drive at negedge, check, advance the model.
    task automatic cyc(input int stg, input logic iresp, input logic dresp, input logic mdone,
                       input logic halt, input logic trap, input logic imem, input logic imdu,
                       input logic first_ex);
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        iresp_ok_i = iresp; dresp_ok_i = dresp; mdu_done_i = mdone;
        halt_i = halt; trap_i = trap; is_mem_i = imem; is_mdu_i = imdu;
        #1;
        case (stg)
            P_IF:    exp_v = {5'b10000, 1'b1, iresp, 5'b00000};
            P_ID:    exp_v = {5'b01000, 7'b0000000};
            P_EX:    exp_v = {5'b00100, 3'b000, (m_mdu & first_ex), 3'b000};
            P_MEM:   exp_v = {5'b00010, 2'b00, m_mem, 4'b0000};
            P_WB:    exp_v = {5'b00001, 4'b0000, 1'b1, trap, 1'b1};
            default: exp_v = 12'b0;
        endcase
        obs_v = observed();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s outputs stage=%0d got %b expected %b", cur_test, stg, obs_v, exp_v);
        end
        n_checks++;
        if (instret_o !== m_instret) begin
            n_errors++;
            $display("FAIL %s instret stage=%0d got %0h expected %0h", cur_test, stg, instret_o, m_instret);
        end
        @(posedge clk);
        if (stg == P_WB) m_instret = m_instret + 64'd1;
        if (stg == P_ID) begin
            m_mem = imem;
            m_mdu = imdu;
        end
        @(negedge clk);
    endtask

    // Whole instruction starting in IF; lat counts cycles from first IF through WB.
    task automatic run_instr(input logic mem, input logic mdu, input logic trap, input int if_d,
                             input int d_d, input int m_d, input int halt_n, output int lat);
        int n_ex;
        int n_mem;
        lat   = 0;
        n_ex  = mdu ? m_d + 1 : 1;
        n_mem = mem ? d_d + 1 : 1;
        for (int k = 0; k <= if_d; k++) begin
            cyc(P_IF, 1'(k == if_d), rb(), rb(), rb(), rb(), rb(), rb(), 1'b0);
            lat++;
        end
        cyc(P_ID, rb(), rb(), rb(), rb(), rb(), mem, mdu, 1'b0);
        lat++;
        for (int k = 0; k < n_ex; k++) begin
            cyc(P_EX, rb(), rb(), mdu ? 1'(k == m_d) : rb(), rb(), rb(), rb(), rb(), 1'(k == 0));
            lat++;
        end
        if (mem || !SKIP_MEM) begin
            for (int k = 0; k < n_mem; k++) begin
                cyc(P_MEM, rb(), mem ? 1'(k == d_d) : rb(), rb(), rb(), rb(), rb(), rb(), 1'b0);
                lat++;
            end
        end
        cyc(P_WB, rb(), rb(), rb(), 1'(halt_n > 0), trap, rb(), rb(), 1'b0);
        lat++;
        for (int k = 0; k < halt_n; k++) begin
            cyc(P_HALT, rb(), rb(), rb(), 1'(k < halt_n - 1), rb(), rb(), rb(), 1'b0);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) cyc(P_IDLE, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 1'b0);
        rst = 1'b0;
        cyc(P_IDLE, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 1'b0);
    endtask

    task automatic test_addi();
        int lat;
        cur_test = "addi";
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, lat);
        n_checks++;
        if (lat !== (SKIP_MEM ? 4 : 5)) begin
            n_errors++;
            $display("FAIL addi latency got %0d expected %0d", lat, SKIP_MEM ? 4 : 5);
        end
    endtask

    task automatic test_load();
        int lat;
        cur_test = "load";
        run_instr(1'b1, 1'b0, 1'b0, 1, 2, 0, 0, lat);
        n_checks++;
        if (lat !== 8) begin
            n_errors++;
            $display("FAIL load latency got %0d expected %0d", lat, 8);
        end
    endtask

    task automatic test_div();
        int lat;
        cur_test = "div";
        run_instr(1'b0, 1'b1, 1'b0, 0, 0, 6, 0, lat);
        n_checks++;
        if (lat !== (SKIP_MEM ? 10 : 11)) begin
            n_errors++;
            $display("FAIL div latency got %0d expected %0d", lat, SKIP_MEM ? 10 : 11);
        end
        cur_test = "div_zero_wait";
        run_instr(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, lat);
    endtask

    task automatic test_halt_trap();
        int lat;
        cur_test = "halt_trap";
        run_instr(1'b0, 1'b0, 1'b1, 0, 0, 0, 4, lat);
        cur_test = "halt_release";
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 1, lat);
    endtask

    task automatic test_reset_mid_mem();
        int lat;
        cur_test = "reset_mid_mem";
        cyc(P_IF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(P_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(P_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(P_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dresp_ok_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m_instret = 64'd0;
        n_checks++;
        if (observed() !== 12'b0) begin
            n_errors++;
            $display("FAIL reset_mid_mem outputs got %b expected %b", observed(), 12'b0);
        end
        n_checks++;
        if (instret_o !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid_mem instret got %0h expected 0", instret_o);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(P_IDLE, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, lat);
    endtask

    task automatic test_instret_wrap();
        int lat;
        cur_test = "instret_wrap";
        dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret     = 64'hFFFF_FFFF_FFFF_FFFF;
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, lat);
        n_checks++;
        if (instret_o !== 64'd0) begin
            n_errors++;
            $display("FAIL instret_wrap got %0h expected 0", instret_o);
        end
    endtask

    task automatic test_random();
        int lat;
        cur_test = "random";
        for (int i = 0; i < 40; i++) begin
            run_instr(rb(), rb(), rb(), $urandom_range(3, 0), $urandom_range(4, 0),
                      $urandom_range(5, 0), ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        {halt_i, iresp_ok_i, dresp_ok_i, is_mem_i, is_mdu_i, mdu_done_i, trap_i} = 7'b0;
        test_reset();
        test_addi();
        test_load();
        test_div();
        test_halt_trap();
        test_reset_mid_mem();
        test_instret_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
